// File: rtl/c1541_track_sched.sv
// c1541_track_sched: moves one D64 track between the SD card and the 8 KB
// GCR track buffer. A dirty track is written back first, then the newly
// selected track is read in. busy stays high while the buffer does not hold
// a complete copy of cur_track.
//
// SD handshake (level based, one block per handshake): sd_rd or sd_wr is
// raised together with a stable sd_lba/blk_idx. The host raises sd_ack and
// holds it for the whole block transfer. The request drops on the cycle after
// sd_ack is seen high. When sd_ack falls, the next block starts or the phase
// ends. sd_lba and blk_idx only change on the sd_ack-fall edge, when both the
// request and sd_ack are low.
module c1541_track_sched #(
  parameter int unsigned SETTLE_CYCLES = 32000,
  parameter logic [31:0] LBA_BASE      = 32'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  track,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic        buf_we,
  input  logic        sd_ack,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [3:0]  blk_idx,
  output logic        buf_odd,
  output logic        busy,
  output logic [5:0]  cur_track,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_FLUSH  = 3'd2,
    ST_LOAD   = 3'd3,
    ST_READY  = 3'd4
  } state_t;

  localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  state_t        state;
  logic [5:0]    new_track;
  logic [5:0]    track_prev;
  logic [CW-1:0] settle_cnt;
  logic          dirty;
  logic          mounted;
  logic          mnt_pend;
  logic          ack_seen;
  logic [5:0]    run_trk;

  // Sectors preceding track t in the D64 image (zoned sectors-per-track).
  function automatic logic [9:0] sec_before(input logic [5:0] t);
    logic [9:0] tt;
    tt = {4'd0, t};
    if (t <= 6'd17)      sec_before = (tt - 10'd1) * 10'd21;
    else if (t <= 6'd24) sec_before = 10'd357 + (tt - 10'd18) * 10'd19;
    else if (t <= 6'd30) sec_before = 10'd490 + (tt - 10'd25) * 10'd18;
    else                 sec_before = 10'd598 + (tt - 10'd31) * 10'd17;
  endfunction

  function automatic logic [9:0] nsec(input logic [5:0] t);
    if (t <= 6'd17)      nsec = 10'd21;
    else if (t <= 6'd24) nsec = 10'd19;
    else if (t <= 6'd30) nsec = 10'd18;
    else                 nsec = 10'd17;
  endfunction

  // First 512-byte block touched by track t.
  function automatic logic [8:0] first_blk(input logic [5:0] t);
    first_blk = 9'(sec_before(t) >> 1);
  endfunction

  // Index of the last block of track t relative to its first block.
  function automatic logic [3:0] last_idx(input logic [5:0] t);
    logic [9:0] s;
    logic [9:0] e;
    s = sec_before(t);
    e = s + nsec(t) - 10'd1;
    last_idx = 4'((e >> 1) - (s >> 1));
  endfunction

  // Track data starts at byte 256 of its first block when S is odd.
  function automatic logic odd_start(input logic [5:0] t);
    odd_start = ((sec_before(t) & 10'd1) != 10'd0);
  endfunction

  function automatic logic trk_ok(input logic [5:0] t);
    trk_ok = (t != 6'd0) && (t <= 6'd35);
  endfunction

  // Geometry source for the phase in progress: write-back uses the buffered
  // track, load uses the track latched when the load was started.
  assign run_trk   = (state == ST_FLUSH) ? cur_track : new_track;
  assign state_dbg = state;

  // Main sequencer: settle timing, flush/load block loops and SD handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      sd_lba     <= 32'd0;
      blk_idx    <= 4'd0;
      buf_odd    <= 1'b0;
      busy       <= 1'b1;
      cur_track  <= 6'd0;
      new_track  <= 6'd0;
      track_prev <= 6'd0;
      settle_cnt <= '0;
      dirty      <= 1'b0;
      mounted    <= 1'b0;
      mnt_pend   <= 1'b0;
      ack_seen   <= 1'b0;
    end else begin
      track_prev <= track;
      case (state)
        ST_IDLE: begin
          busy <= 1'b1;
          if (img_mounted) begin
            mounted    <= 1'b1;
            dirty      <= 1'b0;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else if (mounted && trk_ok(track)) begin
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          busy <= 1'b1;
          if (img_mounted) begin
            mounted    <= 1'b1;
            dirty      <= 1'b0;
            settle_cnt <= '0;
          end else if (!trk_ok(track)) begin
            state <= ST_IDLE;
          end else if (track != track_prev) begin
            settle_cnt <= '0;
          end else if (settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
            blk_idx  <= 4'd0;
            ack_seen <= 1'b0;
            if (dirty) begin
              sd_lba  <= LBA_BASE + {23'd0, first_blk(cur_track)};
              buf_odd <= odd_start(cur_track);
              sd_wr   <= 1'b1;
              state   <= ST_FLUSH;
            end else begin
              new_track <= track;
              sd_lba    <= LBA_BASE + {23'd0, first_blk(track)};
              buf_odd   <= odd_start(track);
              sd_rd     <= 1'b1;
              state     <= ST_LOAD;
            end
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end

        ST_FLUSH, ST_LOAD: begin
          busy <= 1'b1;
          if (img_mounted) begin
            mnt_pend <= 1'b1;
            mounted  <= 1'b1;
          end
          if (!ack_seen) begin
            if (sd_ack) begin
              sd_rd    <= 1'b0;
              sd_wr    <= 1'b0;
              ack_seen <= 1'b1;
            end
          end else if (!sd_ack) begin
            ack_seen <= 1'b0;
            if (mnt_pend || img_mounted) begin
              // New image: whatever was buffered belongs to the old one.
              mnt_pend   <= 1'b0;
              dirty      <= 1'b0;
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else if ((state == ST_LOAD) && (track != new_track)) begin
              // Head moved mid-load: drop the partial track and resettle.
              settle_cnt <= '0;
              state      <= ST_SETTLE;
            end else if (blk_idx != last_idx(run_trk)) begin
              blk_idx <= blk_idx + 4'd1;
              sd_lba  <= sd_lba + 32'd1;
              sd_rd   <= (state == ST_LOAD);
              sd_wr   <= (state == ST_FLUSH);
            end else if (state == ST_FLUSH) begin
              dirty <= 1'b0;
              if (trk_ok(track)) begin
                new_track <= track;
                blk_idx   <= 4'd0;
                sd_lba    <= LBA_BASE + {23'd0, first_blk(track)};
                buf_odd   <= odd_start(track);
                sd_rd     <= 1'b1;
                state     <= ST_LOAD;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              cur_track <= new_track;
              busy      <= 1'b0;
              state     <= ST_READY;
            end
          end
        end

        ST_READY: begin
          busy <= 1'b0;
          if (buf_we && !img_readonly) dirty <= 1'b1;
          if (img_mounted) begin
            mounted    <= 1'b1;
            dirty      <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end else if (!trk_ok(track)) begin
            busy  <= 1'b1;
            state <= ST_IDLE;
          end else if (track != cur_track) begin
            busy       <= 1'b1;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end

        default: begin
          busy  <= 1'b1;
          sd_rd <= 1'b0;
          sd_wr <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_c1541_track_sched.sv
// Testbench for c1541_track_sched: directed track/mount scenarios, an SD host
// responder feeding a scoreboard of expected block requests, and a per-cycle
// protocol/readiness monitor.
`timescale 1ns/1ps
module tb_c1541_track_sched;

  localparam int unsigned SETTLE = 20;
  localparam logic [31:0] BASE   = 32'd0;
  localparam int TW = 37;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  track;
  logic        img_mounted;
  logic        img_readonly;
  logic        buf_we;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic [3:0]  blk_idx;
  logic        buf_odd;
  logic        busy;
  logic [5:0]  cur_track;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  c1541_track_sched #(
    .SETTLE_CYCLES(SETTLE),
    .LBA_BASE     (BASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .track       (track),
    .img_mounted (img_mounted),
    .img_readonly(img_readonly),
    .buf_we      (buf_we),
    .sd_ack      (sd_ack),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .blk_idx     (blk_idx),
    .buf_odd     (buf_odd),
    .busy        (busy),
    .cur_track   (cur_track),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [TW-1:0] exp_q[$];   // {is_write, lba, blk_idx}
  int   mdl_cur = 0;
  logic mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- geometry model ----------------
  function automatic int spt(input int t);
    if (t <= 17) return 21;
    if (t <= 24) return 19;
    if (t <= 30) return 18;
    return 17;
  endfunction

  function automatic int sec_before(input int t);
    int s = 0;
    for (int i = 1; i < t; i++) s += spt(i);
    return s;
  endfunction

  function automatic int m_first(input int t);
    return sec_before(t) / 2;
  endfunction

  function automatic int m_last(input int t);
    return (sec_before(t) + spt(t) - 1) / 2;
  endfunction

  function automatic int m_odd(input int t);
    return sec_before(t) % 2;
  endfunction

  // Queue the block requests a phase must issue (block offsets lo..hi).
  task automatic expect_blocks(input logic wr, input int t, input int lo, input int hi);
    for (int b = lo; b <= hi; b++)
      exp_q.push_back({wr, BASE + 32'(m_first(t) + b), 4'(b)});
  endtask

  task automatic expect_track(input logic wr, input int t);
    expect_blocks(wr, t, 0, m_last(t) - m_first(t));
  endtask

  // ---------------- driver tasks ----------------
  task automatic pulse_we();
    buf_we = 1'b1;
    @(negedge clk);
    buf_we = 1'b0;
  endtask

  task automatic pulse_mount();
    img_mounted = 1'b1;
    @(negedge clk);
    img_mounted = 1'b0;
  endtask

  task automatic wait_req(input logic wr, input int blk);
    int n = 0;
    while (!((wr ? sd_wr : sd_rd) && (blk_idx == 4'(blk))) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_req_timeout", 64'(n >= 3000), 64'd0);
  endtask

  task automatic wait_ready(input int t);
    int n = 0;
    mdl_cur = t;
    repeat (2) @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_busy", 64'(busy), 64'd0);
    chk("ready_cur_track", 64'(cur_track), 64'(t));
    chk("ready_buf_odd", 64'(buf_odd), 64'(m_odd(t)));
    chk("ready_q_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- SD host responder ----------------
  initial begin : sd_host
    logic [TW-1:0] obs;
    logic [TW-1:0] exp;
    int n;
    sd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && (sd_rd || sd_wr) && !sd_ack) begin
        obs = {sd_wr, sd_lba, blk_idx};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sd_unexpected: got wr=%0b lba=%0d blk=%0d expected no request", sd_wr, sd_lba, blk_idx);
        end else begin
          exp = exp_q.pop_front();
          chk("sd_txn", 64'(obs), 64'(exp));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (reset_n) begin
          sd_ack = 1'b1;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while ((sd_rd || sd_wr) && reset_n && n < 16);
          chk("req_drop_timeout", 64'(n >= 16), 64'd0);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          sd_ack = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic        p_rd = 1'b0, p_wr = 1'b0, p_ack = 1'b0;
  logic [31:0] p_lba = 32'd0;
  logic [3:0]  p_blk = 4'd0;

  always @(posedge clk) begin
    #1;
    if (mon_en && reset_n) begin
      chk("rd_wr_exclusive", 64'(sd_rd & sd_wr), 64'd0);
      if ((sd_rd && p_rd) || (sd_wr && p_wr) || (sd_ack && (p_rd || p_wr || p_ack))) begin
        chk("lba_stable", 64'(sd_lba), 64'(p_lba));
        chk("blk_stable", 64'(blk_idx), 64'(p_blk));
      end
      if (!busy) begin
        chk("ready_no_req", 64'({sd_rd, sd_wr}), 64'd0);
        chk("ready_track_cyc", 64'(cur_track), 64'(mdl_cur));
        chk("ready_odd_cyc", 64'(buf_odd), 64'(m_odd(mdl_cur)));
      end
    end
    p_rd  = sd_rd;
    p_wr  = sd_wr;
    p_ack = sd_ack;
    p_lba = sd_lba;
    p_blk = blk_idx;
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int lat;
    track        = 6'd0;
    img_mounted  = 1'b0;
    img_readonly = 1'b0;
    buf_we       = 1'b0;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_sd_rd", 64'(sd_rd), 64'd0);
    chk("rst_sd_wr", 64'(sd_wr), 64'd0);
    chk("rst_sd_lba", 64'(sd_lba), 64'd0);
    chk("rst_blk_idx", 64'(blk_idx), 64'd0);
    chk("rst_buf_odd", 64'(buf_odd), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_cur_track", 64'(cur_track), 64'd0);

    // Pin the geometry model against hand-computed values
    chk("mdl_first_1", 64'(m_first(1)), 64'd0);
    chk("mdl_last_1", 64'(m_last(1)), 64'd10);
    chk("mdl_first_18", 64'(m_first(18)), 64'd178);
    chk("mdl_last_18", 64'(m_last(18)), 64'd187);
    chk("mdl_odd_18", 64'(m_odd(18)), 64'd1);
    chk("mdl_s_19", 64'(sec_before(19)), 64'd376);
    chk("mdl_first_19", 64'(m_first(19)), 64'd188);
    chk("mdl_last_19", 64'(m_last(19)), 64'd197);
    chk("mdl_first_5", 64'(m_first(5)), 64'd42);
    chk("mdl_last_5", 64'(m_last(5)), 64'd52);

    reset_n = 1'b1;
    mon_en  = 1'b1;

    // No image mounted: valid track alone starts nothing
    track = 6'd1;
    repeat (50) @(negedge clk);
    chk("nomount_busy", 64'(busy), 64'd1);

    // Mount at track 1: 11 reads, LBA 0..10
    expect_track(1'b0, 1);
    pulse_mount();
    wait_ready(1);

    // 1 -> 18 clean: reads only, LBA 178..187, odd start
    track = 6'd18;
    expect_track(1'b0, 18);
    wait_ready(18);

    // Dirty 18 -> 19: write back 178..187, then read 188..197
    pulse_we();
    track = 6'd19;
    expect_track(1'b1, 18);
    expect_track(1'b0, 19);
    wait_ready(19);

    // Dirty flag cleared by the flush: next step reads only
    track = 6'd20;
    expect_track(1'b0, 20);
    wait_ready(20);

    // 5 -> 6 -> 5 inside the settle window: one load of track 5
    track = 6'd5;
    repeat (8) @(negedge clk);
    track = 6'd6;
    repeat (8) @(negedge clk);
    track = 6'd5;
    expect_track(1'b0, 5);
    mdl_cur = 5;
    lat = 0;
    while (!sd_rd && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat < int'(SETTLE) || lat > int'(SETTLE) + 3) begin
      errors++;
      $display("FAIL settle_latency: got %0d expected %0d..%0d", lat, SETTLE, SETTLE + 3);
    end
    wait_ready(5);

    // Mount during load block 3 of track 1: block 3 completes, full reload
    track = 6'd1;
    expect_blocks(1'b0, 1, 0, 3);
    expect_track(1'b0, 1);
    wait_req(1'b0, 3);
    pulse_mount();
    wait_ready(1);

    // Write-protected image: buf_we never dirties the track
    img_readonly = 1'b1;
    pulse_we();
    img_readonly = 1'b0;
    track = 6'd2;
    expect_track(1'b0, 2);
    wait_ready(2);

    // Mount coincident with buf_we: mount wins, reload without flush
    buf_we      = 1'b1;
    img_mounted = 1'b1;
    @(negedge clk);
    buf_we      = 1'b0;
    img_mounted = 1'b0;
    expect_track(1'b0, 2);
    wait_ready(2);
    track = 6'd3;
    expect_track(1'b0, 3);
    wait_ready(3);

    // Track 0 with a dirty buffer: idle, then flush once a valid track returns
    pulse_we();
    track = 6'd0;
    repeat (40) @(negedge clk);
    chk("trk0_busy", 64'(busy), 64'd1);
    chk("trk0_no_req", 64'({sd_rd, sd_wr}), 64'd0);
    track = 6'd3;
    expect_track(1'b1, 3);
    expect_track(1'b0, 3);
    wait_ready(3);

    // Track change during flush: flush completes, load uses track at flush end
    pulse_we();
    track = 6'd10;
    expect_track(1'b1, 3);
    expect_track(1'b0, 12);
    wait_req(1'b1, 2);
    track = 6'd12;
    wait_ready(12);

    // Track change during load: block 2 completes, load restarts for new track
    track = 6'd13;
    expect_blocks(1'b0, 13, 0, 2);
    expect_track(1'b0, 14);
    wait_req(1'b0, 2);
    track = 6'd14;
    wait_ready(14);

    // Reset while a read is requested: request drops at once
    track = 6'd15;
    expect_blocks(1'b0, 15, 0, 0);
    wait_req(1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_sd_rd", 64'(sd_rd), 64'd0);
    chk("midrst_sd_wr", 64'(sd_wr), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd1);
    track = 6'd36;
    @(negedge clk);
    reset_n = 1'b1;
    pulse_mount();
    repeat (60) @(negedge clk);
    chk("trk36_busy", 64'(busy), 64'd1);
    chk("trk36_no_req", 64'({sd_rd, sd_wr}), 64'd0);

    repeat (10) @(negedge clk);
    chk("final_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
